// File: rtl/bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_pkg
//  Description : Shared BCD types, constants and helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
package bcd_pkg;

    localparam int DIGIT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } b2b_state_t;

    function automatic logic is_valid_bcd_digit(input logic [DIGIT_W-1:0] digit);
        return (digit <= 4'd9);
    endfunction

    // Constant-evaluable 10**n, used for the width sanity check at elaboration.
    function automatic longint unsigned pow10(input int n);
        longint unsigned acc;
        acc = 64'd1;
        for (int i = 0; i < n; i++) begin
            acc = acc * 64'd10;
        end
        return acc;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adjust
//  Description : Reverse double-dabble digit correction (subtract 3 if >= 8).
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adjust
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    // Only applied to 8..15, so the 4-bit subtract cannot underflow.
    assign o_digit = (i_digit >= 4'd8) ? (i_digit - 4'd3) : i_digit;

endmodule
`default_nettype wire

// File: rtl/bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_to_bin
//  Description : Iterative packed-BCD to binary converter, one bit per clock.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_to_bin
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int BIN_W  = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [DIGIT_W*DIGITS-1:0] bcd_in,
    output logic                      busy,
    output logic                      done,
    output logic [BIN_W-1:0]          bin_out,
    output logic                      bcd_error
);

    localparam int                 c_BCD_W = DIGIT_W * DIGITS;
    localparam int                 c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(BIN_W - 1);

    if ((BIN_W < 63) && ((64'd1 << BIN_W) < pow10(DIGITS))) begin : g_width_check
        $error("bcd_to_bin: BIN_W is too narrow for DIGITS decimal digits");
    end

    b2b_state_t         r_state_q,     w_state_d;
    logic [c_CNT_W-1:0] r_cnt_q,       w_cnt_d;
    logic [c_BCD_W-1:0] r_bcd_q,       w_bcd_d;
    logic [BIN_W-1:0]   r_bin_q,       w_bin_d;
    logic               r_busy_q,      w_busy_d;
    logic               r_done_q,      w_done_d;
    logic [BIN_W-1:0]   r_bin_out_q,   w_bin_out_d;
    logic               r_bcd_error_q, w_bcd_error_d;

    logic [c_BCD_W-1:0] w_bcd_shift;
    logic [c_BCD_W-1:0] w_bcd_adj;
    logic [BIN_W-1:0]   w_bin_shift;
    logic               w_in_valid;

    // The BCD LSB falls into the MSB of the binary half of the shift pair.
    assign w_bcd_shift = r_bcd_q >> 1;
    assign w_bin_shift = {r_bcd_q[0], r_bin_q[BIN_W-1:1]};

    for (genvar g = 0; g < DIGITS; g++) begin : g_adjust
        bcd_digit_adjust u_adjust (
            .i_digit (w_bcd_shift[g*DIGIT_W +: DIGIT_W]),
            .o_digit (w_bcd_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    always_comb begin
        w_in_valid = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (!is_valid_bcd_digit(bcd_in[i*DIGIT_W +: DIGIT_W])) begin
                w_in_valid = 1'b0;
            end
        end
    end

    always_comb begin
        w_state_d     = r_state_q;
        w_cnt_d       = r_cnt_q;
        w_bcd_d       = r_bcd_q;
        w_bin_d       = r_bin_q;
        w_bin_out_d   = r_bin_out_q;
        w_bcd_error_d = r_bcd_error_q;

        case (r_state_q)
            IDLE, DONE: begin
                w_state_d = IDLE;
                if (start) begin
                    if (w_in_valid) begin
                        w_bcd_d   = bcd_in;
                        w_bin_d   = '0;
                        w_cnt_d   = '0;
                        w_state_d = SHIFT;
                    end else begin
                        w_bin_out_d   = '0;
                        w_bcd_error_d = 1'b1;
                        w_state_d     = DONE;
                    end
                end
            end
            SHIFT: begin
                w_bcd_d = w_bcd_adj;
                w_bin_d = w_bin_shift;
                w_cnt_d = r_cnt_q + c_CNT_W'(1);
                if (r_cnt_q == c_LAST) begin
                    w_cnt_d       = '0;
                    w_bin_out_d   = w_bin_shift;
                    w_bcd_error_d = 1'b0;
                    w_state_d     = DONE;
                end
            end
            default: begin
                w_state_d = IDLE;
            end
        endcase

        // Status flags are registered copies of the state being entered.
        w_busy_d = (w_state_d == SHIFT);
        w_done_d = (w_state_d == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q     <= IDLE;
            r_cnt_q       <= '0;
            r_bcd_q       <= '0;
            r_bin_q       <= '0;
            r_busy_q      <= 1'b0;
            r_done_q      <= 1'b0;
            r_bin_out_q   <= '0;
            r_bcd_error_q <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_cnt_q       <= w_cnt_d;
            r_bcd_q       <= w_bcd_d;
            r_bin_q       <= w_bin_d;
            r_busy_q      <= w_busy_d;
            r_done_q      <= w_done_d;
            r_bin_out_q   <= w_bin_out_d;
            r_bcd_error_q <= w_bcd_error_d;
        end
    end

    assign busy      = r_busy_q;
    assign done      = r_done_q;
    assign bin_out   = r_bin_out_q;
    assign bcd_error = r_bcd_error_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_to_bin.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bcd_to_bin
//  Description : Self-checking bench for bcd_to_bin against a decimal model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_to_bin;

    localparam int c_DIGITS = 4;
    localparam int c_BIN_W  = 14;

    logic                  clk;
    logic                  reset;
    logic                  start;
    logic [15:0]           bcd_in;
    logic                  busy;
    logic                  done;
    logic [c_BIN_W-1:0]    bin_out;
    logic                  bcd_error;

    int n_checks;
    int n_errors;

    bcd_to_bin #(
        .DIGITS (c_DIGITS),
        .BIN_W  (c_BIN_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bcd_in    (bcd_in),
        .busy      (busy),
        .done      (done),
        .bin_out   (bin_out),
        .bcd_error (bcd_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Decimal interpretation of the packed digits; invalid words yield 0.
    function automatic void ref_model(input logic [15:0] bcd, output int unsigned val,
                                      output bit err);
        int d;
        val = 0;
        err = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            d = int'((bcd >> (4 * i)) & 16'hF);
            if (d > 9) err = 1'b1;
            val = val * 10 + d;
        end
        if (err) val = 0;
    endfunction

    function automatic logic [15:0] to_bcd(input int unsigned v);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / (10 ** i)) % 10);
        end
        return r;
    endfunction

    // Starts a conversion in the current cycle and follows it to its done pulse.
    // An optional second start is injected in cycle inj_cycle while busy.
    task automatic run_conv(input logic [15:0] bcd, input int inj_cycle,
                            input logic [15:0] inj_bcd);
        int unsigned        exp_bin;
        bit                 exp_err;
        int                 n;
        int                 busy_n;
        bit                 seen;
        bit                 moved;
        logic [c_BIN_W-1:0] prev_bin;
        logic               prev_err;

        ref_model(bcd, exp_bin, exp_err);
        prev_bin = bin_out;
        prev_err = bcd_error;
        moved    = 1'b0;
        start    = 1'b1;
        bcd_in   = bcd;
        @(posedge clk); #1;
        start  = 1'b0;
        bcd_in = 16'($urandom);
        n      = 1;
        busy_n = 0;
        seen   = 1'b0;
        while (n <= 40 && !seen) begin
            if (n == inj_cycle) begin
                start  = 1'b1;
                bcd_in = inj_bcd;
            end else begin
                start  = 1'b0;
                bcd_in = 16'($urandom);
            end
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (bin_out !== prev_bin || bcd_error !== prev_err) moved = 1'b1;
                @(posedge clk); #1;
                n++;
            end
        end
        start = 1'b0;
        check_eq("done_seen", seen, 1);
        check_eq("latency", n, exp_err ? 1 : c_BIN_W + 1);
        check_eq("bin_out", bin_out, exp_bin);
        check_eq("bcd_error", bcd_error, exp_err);
        check_eq("busy_cycles", busy_n, exp_err ? 0 : c_BIN_W);
        check_eq("busy_at_done", busy, 0);
        check_eq("hold_between_done", moved, 0);
        if (!exp_err) check_eq("bcd_residue", dut.r_bcd_q, 0);
    endtask

    task automatic expect_no_done(input int cycles);
        bit got;
        got = 1'b0;
        repeat (cycles) begin
            @(posedge clk); #1;
            if (done) got = 1'b1;
        end
        check_eq("no_extra_done", got, 0);
    endtask

    initial begin
        logic [15:0] bcd;
        int unsigned v;

        n_checks = 0;
        n_errors = 0;
        reset    = 1'b1;
        start    = 1'b0;
        bcd_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_bin_out", bin_out, 0);
        check_eq("reset_bcd_error", bcd_error, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_conv(16'h0000, 0, 16'h0000);
        run_conv(16'h9999, 0, 16'h0000);

        // Second request lands in the first one's done cycle.
        run_conv(16'h0255, 0, 16'h0000);
        run_conv(16'h1024, 0, 16'h0000);

        run_conv(16'h12A4, 0, 16'h0000);
        run_conv(16'h0001, 0, 16'h0000);

        run_conv(16'h4321, 5, 16'h0007);
        expect_no_done(20);

        start  = 1'b1;
        bcd_in = 16'h8888;
        @(posedge clk); #1;
        start  = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check_eq("busy_before_reset", busy, 1);
        reset = 1'b1;
        #1;
        check_eq("abort_busy", busy, 0);
        check_eq("abort_done", done, 0);
        check_eq("abort_bin_out", bin_out, 0);
        check_eq("abort_bcd_error", bcd_error, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        expect_no_done(20);
        run_conv(16'h0042, 0, 16'h0000);

        for (int k = 0; k < 2400; k++) begin
            v   = $urandom_range(0, 9999);
            bcd = to_bcd(v);
            run_conv(bcd, 0, 16'h0000);
        end

        for (int k = 0; k < 200; k++) begin
            bcd = 16'($urandom);
            bcd[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            run_conv(bcd, 0, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
